secure_region_store: RTL and testbench

Parametrised protected memory with per-region read/write permissions, privileged/unprivileged requesters, a lockable permission table, a power-on scrub and a violation counter. It is the next-generation secure storage for the security subsystem. It defaults to deny-all for unprivileged access and zero-fills its contents after reset. It sits between the system request fabric and on-chip secret storage (keys, configuration blobs).

---
 rtl/secure_region_store.sv | 135 +++++++++++++
 tb/tb_secure_region_store.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/secure_region_store.sv
// Protected word store with per-region unprivileged permissions,
// a sticky-lockable permission table, power-on scrub and violation count.
module secure_region_store #(
  parameter int          DATA_W      = 32,
  parameter int          ADDR_W      = 8,
  parameter int          REGION_BITS = 2,
  parameter logic [31:0] DENY_VALUE  = 32'hDEAD_BEEF,
  parameter int          VIOL_W      = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic                   req_priv,
  input  logic [ADDR_W-1:0]      req_addr,
  input  logic [DATA_W-1:0]      req_wdata,
  output logic                   rsp_valid,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic                   rsp_err,
  input  logic                   cfg_we,
  input  logic                   cfg_priv,
  input  logic [REGION_BITS-1:0] cfg_region,
  input  logic [1:0]             cfg_perm,
  input  logic                   cfg_lock,
  output logic                   locked,
  output logic                   scrub_busy,
  output logic [VIOL_W-1:0]      viol_cnt,
  input  logic                   viol_clr
);

  localparam int DEPTH   = 2 ** ADDR_W;
  localparam int REGIONS = 2 ** REGION_BITS;
  localparam logic [DATA_W-1:0] DENY_D   = DATA_W'(DENY_VALUE);
  localparam logic [VIOL_W-1:0] VIOL_MAX = '1;

  typedef enum logic {S_SCRUB, S_IDLE} state_e;

  state_e                       state_q;
  logic [ADDR_W-1:0]            ptr_q;
  logic [REGIONS-1:0][1:0]      perm_q;
  logic                         locked_q;
  logic [VIOL_W-1:0]            viol_q;
  logic [VIOL_W-1:0]            viol_d;
  logic                         rsp_valid_q;
  logic [DATA_W-1:0]            rsp_rdata_q;
  logic                         rsp_err_q;
  logic [DATA_W-1:0]            mem_q [DEPTH];

  logic                         idle;
  logic                         accept;
  logic [REGION_BITS-1:0]       region;
  logic [1:0]                   perm_r;
  logic                         rd_ok;
  logic                         wr_ok;
  logic                         req_ok;
  logic                         req_deny;
  logic                         cfg_ok;
  logic                         cfg_viol;
  logic [VIOL_W:0]              viol_sum;

  assign idle     = (state_q == S_IDLE);
  assign accept   = req_valid && idle;
  assign region   = req_addr[ADDR_W-1 -: REGION_BITS];
  assign perm_r   = perm_q[region];
  assign rd_ok    = req_priv | perm_r[0];
  assign wr_ok    = req_priv | perm_r[1];
  assign req_ok   = req_write ? wr_ok : rd_ok;
  assign req_deny = accept & ~req_ok;
  assign cfg_ok   = idle & cfg_we & cfg_priv & ~locked_q;
  assign cfg_viol = idle & cfg_we & (~cfg_priv | locked_q);

  // Up to two violations per cycle; widen by one bit to detect overflow.
  assign viol_sum = {1'b0, viol_q}
                  + (VIOL_W+1)'(req_deny)
                  + (VIOL_W+1)'(cfg_viol);

  always_comb begin
    viol_d = viol_sum[VIOL_W-1:0];
    if (viol_sum > {1'b0, VIOL_MAX}) viol_d = VIOL_MAX;
    if (viol_clr)                    viol_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_SCRUB;
      ptr_q       <= '0;
      perm_q      <= '0;
      locked_q    <= 1'b0;
      viol_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_SCRUB: begin
          ptr_q <= ptr_q + ADDR_W'(1);
          if (&ptr_q) state_q <= S_IDLE;
        end
        S_IDLE: begin
          if (cfg_ok) begin
            perm_q[cfg_region] <= cfg_perm;
            if (cfg_lock) locked_q <= 1'b1;
          end
        end
      endcase
      rsp_valid_q <= accept;
      if (accept) begin
        rsp_err_q <= ~req_ok;
        if (req_write)   rsp_rdata_q <= '0;
        else if (rd_ok)  rsp_rdata_q <= mem_q[req_addr];
        else             rsp_rdata_q <= DENY_D;
      end
      viol_q <= viol_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (!idle)
        mem_q[ptr_q] <= '0;
      else if (accept && req_write && wr_ok)
        mem_q[req_addr] <= req_wdata;
    end
  end

  assign req_ready  = idle;
  assign scrub_busy = ~idle;
  assign locked     = locked_q;
  assign viol_cnt   = viol_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_secure_region_store.sv
// Directed bench for secure_region_store: scrub, deny/grant,
// lock, simultaneous violations, saturation and mid-scrub reset.
module tb_secure_region_store;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic        req_priv;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        cfg_we;
  logic        cfg_priv;
  logic [1:0]  cfg_region;
  logic [1:0]  cfg_perm;
  logic        cfg_lock;
  logic        locked;
  logic        scrub_busy;
  logic [7:0]  viol_cnt;
  logic        viol_clr;

  int nvec = 0;
  int nerr = 0;
  int n;

  secure_region_store dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_priv(req_priv),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .cfg_we(cfg_we), .cfg_priv(cfg_priv), .cfg_region(cfg_region),
    .cfg_perm(cfg_perm), .cfg_lock(cfg_lock), .locked(locked),
    .scrub_busy(scrub_busy), .viol_cnt(viol_cnt), .viol_clr(viol_clr)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic w, input logic p,
                     input logic [7:0] a, input logic [31:0] d);
    req_valid = 1'b1;
    req_write = w;
    req_priv  = p;
    req_addr  = a;
    req_wdata = d;
    step();
    req_valid = 1'b0;
  endtask

  task automatic cfg(input logic p, input logic [1:0] r,
                     input logic [1:0] pm, input logic lk);
    cfg_we     = 1'b1;
    cfg_priv   = p;
    cfg_region = r;
    cfg_perm   = pm;
    cfg_lock   = lk;
    step();
    cfg_we     = 1'b0;
    cfg_lock   = 1'b0;
  endtask

  task automatic count_scrub();
    n = 0;
    while (req_ready === 1'b0 && n < 1000) begin
      step();
      n++;
    end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b1; req_write = 1'b0;
    req_priv = 1'b0; req_addr = '0; req_wdata = '0;
    cfg_we = 1'b0; cfg_priv = 1'b0; cfg_region = '0;
    cfg_perm = '0; cfg_lock = 1'b0; viol_clr = 1'b0;
    step();
    step();
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_viol", 32'(viol_cnt), 32'd0);
    chk("rst_busy", 32'(scrub_busy), 32'd1);

    rst_n = 1'b1;
    count_scrub();
    req_valid = 1'b0;
    chk("scrub_cycles", 32'(n), 32'd256);
    chk("scrub_busy_done", 32'(scrub_busy), 32'd0);
    chk("scrub_viol", 32'(viol_cnt), 32'd0);

    req(1'b0, 1'b1, 8'hFF, 32'h0);
    chk("rd_ff_valid", 32'(rsp_valid), 32'd1);
    chk("rd_ff_data", rsp_rdata, 32'h0);
    chk("rd_ff_err", 32'(rsp_err), 32'd0);
    step();
    chk("rsp_pulse", 32'(rsp_valid), 32'd0);

    req(1'b1, 1'b1, 8'h40, 32'h1234_5678);
    chk("pwr40_err", 32'(rsp_err), 32'd0);
    chk("pwr40_rdata", rsp_rdata, 32'd0);
    req(1'b0, 1'b0, 8'h40, 32'h0);
    chk("deny_data", rsp_rdata, 32'hDEAD_BEEF);
    chk("deny_err", 32'(rsp_err), 32'd1);
    chk("deny_viol", 32'(viol_cnt), 32'd1);

    viol_clr = 1'b1;
    step();
    viol_clr = 1'b0;
    chk("clr_viol", 32'(viol_cnt), 32'd0);

    cfg(1'b1, 2'd1, 2'b01, 1'b0);
    req(1'b0, 1'b0, 8'h40, 32'h0);
    chk("grant_rd_data", rsp_rdata, 32'h1234_5678);
    chk("grant_rd_err", 32'(rsp_err), 32'd0);
    req(1'b1, 1'b0, 8'h41, 32'hFFFF_FFFF);
    chk("grant_wr_err", 32'(rsp_err), 32'd1);
    chk("grant_wr_rdata", rsp_rdata, 32'd0);
    chk("grant_wr_viol", 32'(viol_cnt), 32'd1);
    req(1'b0, 1'b1, 8'h41, 32'h0);
    chk("mem41_unchanged", rsp_rdata, 32'h0);

    req(1'b1, 1'b1, 8'h80, 32'hA5A5_A5A5);
    req(1'b0, 1'b1, 8'h80, 32'h0);
    chk("raw_80", rsp_rdata, 32'hA5A5_A5A5);

    cfg(1'b1, 2'd2, 2'b11, 1'b1);
    chk("lock_set", 32'(locked), 32'd1);
    chk("lock_viol0", 32'(viol_cnt), 32'd1);
    cfg(1'b1, 2'd2, 2'b00, 1'b0);
    chk("lock_viol", 32'(viol_cnt), 32'd2);
    chk("lock_held", 32'(locked), 32'd1);
    req(1'b1, 1'b0, 8'h80, 32'h1111_1111);
    chk("r2_wr_err", 32'(rsp_err), 32'd0);
    req(1'b0, 1'b0, 8'h80, 32'h0);
    chk("r2_rd_data", rsp_rdata, 32'h1111_1111);
    chk("r2_rd_err", 32'(rsp_err), 32'd0);

    req_valid = 1'b1; req_write = 1'b1; req_priv = 1'b0;
    req_addr = 8'h00; req_wdata = 32'h5;
    cfg_we = 1'b1; cfg_priv = 1'b0; cfg_region = 2'd0; cfg_perm = 2'b11;
    step();
    chk("simul_err", 32'(rsp_err), 32'd1);
    chk("simul_viol", 32'(viol_cnt), 32'd4);
    viol_clr = 1'b1;
    step();
    viol_clr = 1'b0; cfg_we = 1'b0; req_valid = 1'b0;
    chk("simul_clr", 32'(viol_cnt), 32'd0);

    req_valid = 1'b1; req_write = 1'b0; req_priv = 1'b0; req_addr = 8'h00;
    for (int i = 0; i < 300; i++) step();
    req_valid = 1'b0;
    chk("sat_viol", 32'(viol_cnt), 32'd255);
    chk("sat_err", 32'(rsp_err), 32'd1);

    rst_n = 1'b0;
    step();
    chk("rst2_locked", 32'(locked), 32'd0);
    chk("rst2_viol", 32'(viol_cnt), 32'd0);
    chk("rst2_valid", 32'(rsp_valid), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) step();
    chk("mid_busy", 32'(scrub_busy), 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    count_scrub();
    chk("rescrub_cycles", 32'(n), 32'd256);
    chk("rescrub_locked", 32'(locked), 32'd0);
    req(1'b0, 1'b0, 8'h80, 32'h0);
    chk("rescrub_perm_err", 32'(rsp_err), 32'd1);
    chk("rescrub_perm_data", rsp_rdata, 32'hDEAD_BEEF);
    req(1'b0, 1'b1, 8'h80, 32'h0);
    chk("rescrub_mem", rsp_rdata, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
